interruption_ctrl: RTL and testbench
====================================

INTERRUPTION_CTRL -- requirements
Module: interruption_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 64, giving the task-cycle counter and breakpoint width.
REQ-002 SHALL have parameter NUM_BP, default 4, giving the number of breakpoint channels.
REQ-003 SHALL have parameter STEP_W, default 16, giving the single-step count width.
REQ-004 SHALL have port sys_clk, input, 1, the only clock.
REQ-005 SHALL have port sys_rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port clk_en, input, 1, master task-clock enable (level).
REQ-007 SHALL have port difftest_break, input, 1, external break request (level).
REQ-008 SHALL have port bp_value, input, NUM_BP*CNT_W, breakpoint counts with channel i in bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port bp_arm, input, NUM_BP, a one-cycle pulse per channel that arms that channel.
REQ-010 SHALL have port bp_disarm, input, NUM_BP, a one-cycle pulse per channel that disarms that channel.
REQ-011 SHALL have port resume, input, 1, a one-cycle pulse requesting HALT->RUN.
REQ-012 SHALL have port step_req, input, 1, a one-cycle pulse requesting HALT->STEP.
REQ-013 SHALL have port step_n, input, STEP_W, the number of task cycles per step request.
REQ-014 SHALL have port task_clk, output, 1, the gated sys_clk.
REQ-015 SHALL have port task_clk_ce, output, 1, the gate enable driving task_clk.
REQ-016 SHALL have port state, output, 2, the current state encoding.
REQ-017 SHALL have port halt_cause, output, NUM_BP+2, with bits [NUM_BP-1:0] as breakpoint hits, bit NUM_BP as external break, and bit NUM_BP+1 as step done.
REQ-018 SHALL have port cycle_count, output, CNT_W, the number of task cycles delivered.
REQ-019 SHALL have port armed, output, NUM_BP, the per-channel armed flags.
REQ-020 SHALL have port cnt_ovf, output, 1, a sticky counter wrap flag.

Function
REQ-021 SHALL implement states RUN=0, STEP=1, HALT=2; encoding 3 SHALL be illegal and SHALL recover to HALT on the next cycle.
REQ-022 SHALL register difftest_break once into brk_q; only brk_q SHALL be used internally.
REQ-023 SHALL compute hit[i] combinationally as armed[i] & (cycle_count == bp_value channel i).
REQ-024 SHALL drive task_clk_ce = clk_en & (state==RUN | state==STEP) & ~|hit & ~brk_q, combinationally.
REQ-025 SHALL increment cycle_count by 1 in every cycle where task_clk_ce=1, so a breakpoint of value V delivers exactly V task cycles before halting.
REQ-026 SHALL wrap cycle_count from all-ones to 0 and set cnt_ovf, which stays set until reset.
REQ-027 In RUN or STEP, with clk_en=1, if |hit or brk_q, SHALL go to HALT next cycle and load halt_cause with {0, brk_q, hit}.
REQ-028 On entry to HALT, SHALL clear armed[i] for every channel with hit[i]=1 (auto-disarm, preventing immediate re-halt).
REQ-029 With clk_en=0, SHALL hold state, cycle_count and step counter; hit and brk_q SHALL NOT cause transitions.
REQ-030 In HALT, resume SHALL go to RUN and clear halt_cause, but SHALL be ignored while brk_q=1.
REQ-031 In HALT, step_req SHALL load step_rem=max(step_n,1), go to STEP and clear halt_cause, and SHALL be ignored while brk_q=1.
REQ-032 If resume and step_req arrive in the same cycle, step_req SHALL win.
REQ-033 In STEP, step_rem SHALL decrement on each task_clk_ce=1 cycle.
REQ-034 In STEP, when step_rem reaches 1 with task_clk_ce=1, SHALL go to HALT and set halt_cause bit NUM_BP+1.
REQ-035 A breakpoint or external break during STEP SHALL take priority over step done.
REQ-036 resume and step_req SHALL be ignored in RUN and STEP.
REQ-037 If bp_arm[i] and bp_disarm[i] arrive in the same cycle, arm SHALL win.
REQ-038 Arm pulses SHALL be accepted in any state, including HALT.
REQ-039 Multiple simultaneous hits, and a hit coinciding with brk_q, SHALL all be recorded in halt_cause.

Reset
REQ-040 While sys_rst=1, the block SHALL set state=RUN, cycle_count=0, step_rem=0, halt_cause=0, armed=0, cnt_ovf=0 and brk_q=0.
REQ-041 While sys_rst=1, task_clk_ce SHALL be 0.
REQ-042 Reset asserted mid-STEP or in HALT SHALL abandon the operation with no residual cause or arm state.

Structure
REQ-043 The package interruption_pkg SHALL hold the state enum, the halt_cause bit-index constants and the default parameter values.
REQ-044 The sub-module clk_gate_cell SHALL wrap the BUFGCE primitive (I=sys_clk, CE=task_clk_ce, O=task_clk); all logic SHALL be synchronous to sys_clk.

Verification
REQ-045 Reset, then clk_en=1, arm ch0 with bp_value0=10 -> exactly 10 task_clk edges, HALT, halt_cause=0b000001, cycle_count=10, armed[0]=0.
REQ-046 In HALT at 10, step_n=3 and step_req -> 3 task edges, cycle_count=13, halt_cause bit NUM_BP+1 set; then step_n=0 -> 1 edge.
REQ-047 In RUN, assert difftest_break -> HALT 2 cycles later with cause bit NUM_BP; resume ignored while the break is high and accepted after it falls.
REQ-048 Arm ch1=ch2=20 -> halt at 20 with cause 0b000110; resume and step_req pulsed together -> STEP wins.
REQ-049 CNT_W=4, no breakpoints armed, run 17 task cycles -> cycle_count=1, cnt_ovf=1.
REQ-050 Toggle clk_en=0 mid-STEP -> no task edges and counters hold; assert sys_rst mid-STEP -> all outputs at reset values, state=RUN.

Source files
------------

// File: rtl/interruption_pkg.sv
// Shared types and constants for the task-clock interruption controller.
package interruption_pkg;

  localparam int unsigned DefCntW  = 64;
  localparam int unsigned DefNumBp = 4;
  localparam int unsigned DefStepW = 16;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StStep = 2'd1,
    StHalt = 2'd2
  } state_e;

  // halt_cause bit positions, as offsets above the NUM_BP breakpoint-hit bits
  localparam int unsigned CauseBrkOfs  = 0;
  localparam int unsigned CauseStepOfs = 1;

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: BUFGCE on the FPGA target, equivalent behavioural model otherwise.
module clk_gate_cell (
  input  logic sys_clk,
  input  logic task_clk_ce,
  output logic task_clk
);

`ifdef USE_BUFGCE
  BUFGCE u_bufgce (
    .I  (sys_clk),
    .CE (task_clk_ce),
    .O  (task_clk)
  );
`else
  // Enable is captured while the clock is low, so the output never produces a runt pulse.
  logic ce_lo_q;

  always_ff @(negedge sys_clk) begin
    ce_lo_q <= task_clk_ce;
  end

  assign task_clk = sys_clk & ce_lo_q;
`endif

endmodule

// File: rtl/interruption_ctrl.sv
// Task-clock controller: run/step/halt FSM with cycle-count breakpoints and external break.
module interruption_ctrl
  import interruption_pkg::*;
#(
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned NUM_BP = DefNumBp,
  parameter int unsigned STEP_W = DefStepW
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    clk_en,
  input  logic                    difftest_break,
  input  logic [NUM_BP*CNT_W-1:0] bp_value,
  input  logic [NUM_BP-1:0]       bp_arm,
  input  logic [NUM_BP-1:0]       bp_disarm,
  input  logic                    resume,
  input  logic                    step_req,
  input  logic [STEP_W-1:0]       step_n,
  output logic                    task_clk,
  output logic                    task_clk_ce,
  output logic [1:0]              state,
  output logic [NUM_BP+1:0]       halt_cause,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [NUM_BP-1:0]       armed,
  output logic                    cnt_ovf
);

  localparam logic [NUM_BP+1:0] StepDoneCause = (NUM_BP+2)'(1) << (NUM_BP + CauseStepOfs);
  localparam logic [STEP_W-1:0] StepOne       = STEP_W'(1);

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [STEP_W-1:0] step_rem_q;
  logic [NUM_BP+1:0] cause_q;
  logic [NUM_BP-1:0] armed_q, armed_d;
  logic              ovf_q;
  logic              brk_q;

  logic [NUM_BP-1:0] hit;
  logic              running;
  logic              ce;

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_BP); i++) begin
      hit[i] = armed_q[i] & (cnt_q == bp_value[i*CNT_W +: CNT_W]);
    end
  end

  assign running = (state_q == StRun) || (state_q == StStep);
  assign ce      = ~sys_rst & clk_en & running & ~|hit & ~brk_q;

  // Hit channels auto-disarm on the halt they cause; an arm pulse still wins.
  always_comb begin
    armed_d = armed_q;
    if (clk_en && running) begin
      armed_d = armed_d & ~hit;
    end
    armed_d = (armed_d & ~bp_disarm) | bp_arm;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      step_rem_q <= '0;
      cause_q    <= '0;
      armed_q    <= '0;
      ovf_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      brk_q   <= difftest_break;
      armed_q <= armed_d;
      if (ce) begin
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) begin
          ovf_q <= 1'b1;
        end
      end
      if (state_q == 2'd3) begin
        state_q <= StHalt;
      end else if (clk_en) begin
        if (running && (|hit || brk_q)) begin
          state_q <= StHalt;
          cause_q <= {1'b0, brk_q, hit};
        end else if (state_q == StStep && ce) begin
          step_rem_q <= step_rem_q - 1'b1;
          if (step_rem_q == StepOne) begin
            state_q <= StHalt;
            cause_q <= StepDoneCause;
          end
        end else if (state_q == StHalt && !brk_q) begin
          if (step_req) begin
            step_rem_q <= (step_n == '0) ? StepOne : step_n;
            state_q    <= StStep;
            cause_q    <= '0;
          end else if (resume) begin
            state_q <= StRun;
            cause_q <= '0;
          end
        end
      end
    end
  end

  assign task_clk_ce = ce;
  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign cycle_count = cnt_q;
  assign armed       = armed_q;
  assign cnt_ovf     = ovf_q;

  clk_gate_cell u_clk_gate (
    .sys_clk     (sys_clk),
    .task_clk_ce (ce),
    .task_clk    (task_clk)
  );

endmodule

// File: tb/tb_interruption_ctrl.sv
// Self-checking bench: directed scenarios plus randomized run against a cycle-level reference model.
module tb_interruption_ctrl;

  localparam int unsigned CW = 64;
  localparam int unsigned NB = 4;
  localparam int unsigned SW = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst, clk_en, difftest_break, resume, step_req;
  logic [NB*CW-1:0]  bp_value;
  logic [NB-1:0]     bp_arm, bp_disarm;
  logic [SW-1:0]     step_n;
  logic              task_clk, task_clk_ce, cnt_ovf;
  logic [1:0]        state;
  logic [NB+1:0]     halt_cause;
  logic [CW-1:0]     cycle_count;
  logic [NB-1:0]     armed;

  // Narrow-counter instance for wrap checks
  logic              s_rst, s_en;
  logic [NB*4-1:0]   s_bp_value;
  logic [NB-1:0]     s_arm, s_disarm;
  logic [SW-1:0]     s_step_n;
  logic              s_task_clk, s_ce, s_ovf;
  logic [1:0]        s_state;
  logic [NB+1:0]     s_cause;
  logic [3:0]        s_count;
  logic [NB-1:0]     s_armed;

  int tests = 0;
  int failed = 0;
  int edges = 0;
  int s_edges = 0;

  // Reference model state
  int          m_state;
  logic [63:0] m_cnt;
  int          m_rem;
  logic [5:0]  m_cause;
  logic [3:0]  m_armed;
  bit          m_ovf, m_brk;

  always #5 sys_clk = ~sys_clk;
  always @(posedge task_clk) edges++;
  always @(posedge s_task_clk) s_edges++;

  interruption_ctrl dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .clk_en         (clk_en),
    .difftest_break (difftest_break),
    .bp_value       (bp_value),
    .bp_arm         (bp_arm),
    .bp_disarm      (bp_disarm),
    .resume         (resume),
    .step_req       (step_req),
    .step_n         (step_n),
    .task_clk       (task_clk),
    .task_clk_ce    (task_clk_ce),
    .state          (state),
    .halt_cause     (halt_cause),
    .cycle_count    (cycle_count),
    .armed          (armed),
    .cnt_ovf        (cnt_ovf)
  );

  interruption_ctrl #(.CNT_W(4), .NUM_BP(NB), .STEP_W(SW)) dut_small (
    .sys_clk        (sys_clk),
    .sys_rst        (s_rst),
    .clk_en         (s_en),
    .difftest_break (1'b0),
    .bp_value       (s_bp_value),
    .bp_arm         (s_arm),
    .bp_disarm      (s_disarm),
    .resume         (1'b0),
    .step_req       (1'b0),
    .step_n         (s_step_n),
    .task_clk       (s_task_clk),
    .task_clk_ce    (s_ce),
    .state          (s_state),
    .halt_cause     (s_cause),
    .cycle_count    (s_count),
    .armed          (s_armed),
    .cnt_ovf        (s_ovf)
  );

  function automatic logic [3:0] mdl_hits();
    logic [3:0] h;
    for (int i = 0; i < 4; i++) h[i] = m_armed[i] && (m_cnt == bp_value[i*64 +: 64]);
    return h;
  endfunction

  function automatic bit mdl_ce();
    return !sys_rst && clk_en && (m_state != 2) && (mdl_hits() == 0) && !m_brk;
  endfunction

  // Advance the model one sys_clk cycle from the currently applied inputs.
  task automatic mdl_step();
    logic [3:0] h;
    bit         ce;
    int         ns, nr;
    logic [5:0] nc;
    logic [3:0] na;
    if (sys_rst) begin
      m_state = 0; m_cnt = 0; m_rem = 0; m_cause = 0; m_armed = 0; m_ovf = 0; m_brk = 0;
      return;
    end
    h  = mdl_hits();
    ce = mdl_ce();
    ns = m_state; nr = m_rem; nc = m_cause; na = m_armed;
    if (clk_en && m_state != 2 && (h != 0 || m_brk)) begin
      ns = 2;
      nc = {1'b0, m_brk, h};
      na = na & ~h;
    end else if (clk_en && m_state == 1 && ce) begin
      nr = m_rem - 1;
      if (m_rem == 1) begin ns = 2; nc = 6'b100000; end
    end else if (clk_en && m_state == 2 && !m_brk) begin
      if (step_req) begin
        nr = (step_n == 0) ? 1 : int'(step_n); ns = 1; nc = 0;
      end else if (resume) begin
        ns = 0; nc = 0;
      end
    end
    na = (na & ~bp_disarm) | bp_arm;
    if (ce) begin
      if (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf = 1;
      m_cnt = m_cnt + 1;
    end
    m_state = ns; m_rem = nr; m_cause = nc; m_armed = na; m_brk = difftest_break;
  endtask

  task automatic tick();
    mdl_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_halt(input int max_cycles);
    int n = 0;
    while (state !== 2'd2 && n < max_cycles) begin
      tick();
      n++;
    end
    tests++;
    if (state !== 2'd2) begin
      failed++;
      $display("FAIL wait_halt: state=%0d after %0d cycles, want 2", state, n);
    end
  endtask

  task automatic test_reset();
    clk_en = 0; difftest_break = 0; bp_value = '0; bp_arm = 0; bp_disarm = 0;
    resume = 0; step_req = 0; step_n = 0; sys_rst = 1;
    s_rst = 1; s_en = 0; s_bp_value = '0; s_arm = 0; s_disarm = 0; s_step_n = 0;
    repeat (3) tick();
    tests++; if (state !== 2'd0) begin failed++; $display("FAIL rst_state: got %0d want 0", state); end
    tests++; if (cycle_count !== 64'd0) begin failed++; $display("FAIL rst_count: got %0d want 0", cycle_count); end
    tests++; if (halt_cause !== 6'd0) begin failed++; $display("FAIL rst_cause: got %b want 0", halt_cause); end
    tests++; if (armed !== 4'd0 || cnt_ovf !== 1'b0) begin
      failed++; $display("FAIL rst_armed_ovf: got %b/%b want 0000/0", armed, cnt_ovf); end
    clk_en = 1;
    #1;
    tests++; if (task_clk_ce !== 1'b0) begin failed++; $display("FAIL rst_ce: got %b want 0", task_clk_ce); end
    clk_en = 0;
    sys_rst = 0;
    tick();
  endtask

  task automatic test_breakpoint();
    int e0;
    bp_value[0 +: 64] = 64'd10;
    bp_arm = 4'b0001;
    tick();
    bp_arm = 0;
    tests++; if (armed !== 4'b0001) begin failed++; $display("FAIL bp_armed: got %b want 0001", armed); end
    e0 = edges;
    clk_en = 1;
    wait_halt(50);
    tests++; if (edges - e0 != 10) begin failed++; $display("FAIL bp_edges: got %0d want 10", edges - e0); end
    tests++; if (halt_cause !== 6'b000001) begin failed++; $display("FAIL bp_cause: got %b want 000001", halt_cause); end
    tests++; if (cycle_count !== 64'd10) begin failed++; $display("FAIL bp_count: got %0d want 10", cycle_count); end
    tests++; if (armed !== 4'b0000) begin failed++; $display("FAIL bp_autodisarm: got %b want 0000", armed); end
  endtask

  task automatic test_step();
    int e0;
    step_n = 3; e0 = edges;
    step_req = 1; tick(); step_req = 0;
    tests++; if (state !== 2'd1) begin failed++; $display("FAIL step_enter: got %0d want 1", state); end
    wait_halt(20);
    tests++; if (edges - e0 != 3) begin failed++; $display("FAIL step3_edges: got %0d want 3", edges - e0); end
    tests++; if (cycle_count !== 64'd13) begin failed++; $display("FAIL step3_count: got %0d want 13", cycle_count); end
    tests++; if (halt_cause !== 6'b100000) begin failed++; $display("FAIL step3_cause: got %b want 100000", halt_cause); end
    step_n = 0; e0 = edges;
    step_req = 1; tick(); step_req = 0;
    wait_halt(20);
    tests++; if (edges - e0 != 1) begin failed++; $display("FAIL step0_edges: got %0d want 1", edges - e0); end
    tests++; if (cycle_count !== 64'd14) begin failed++; $display("FAIL step0_count: got %0d want 14", cycle_count); end
  endtask

  task automatic test_ext_break();
    resume = 1; tick(); resume = 0;
    tests++; if (state !== 2'd0 || halt_cause !== 6'd0) begin
      failed++; $display("FAIL resume_run: got state %0d cause %b want 0/000000", state, halt_cause); end
    difftest_break = 1;
    tick();
    tests++; if (state !== 2'd0) begin failed++; $display("FAIL brk_lat1: got %0d want 0", state); end
    tick();
    tests++; if (state !== 2'd2) begin failed++; $display("FAIL brk_halt: got %0d want 2", state); end
    tests++; if (halt_cause !== 6'b010000) begin failed++; $display("FAIL brk_cause: got %b want 010000", halt_cause); end
    resume = 1; tick(); resume = 0;
    tests++; if (state !== 2'd2) begin failed++; $display("FAIL brk_resume_ignored: got %0d want 2", state); end
    difftest_break = 0;
    tick();
    resume = 1; tick(); resume = 0;
    tests++; if (state !== 2'd0) begin failed++; $display("FAIL brk_resume_after: got %0d want 0", state); end
  endtask

  task automatic test_multi_hit();
    clk_en = 0; sys_rst = 1; tick(); sys_rst = 0;
    bp_value[64 +: 64] = 64'd20; bp_value[128 +: 64] = 64'd20;
    bp_arm = 4'b0110; tick(); bp_arm = 0;
    clk_en = 1;
    wait_halt(60);
    tests++; if (halt_cause !== 6'b000110) begin failed++; $display("FAIL multi_cause: got %b want 000110", halt_cause); end
    tests++; if (cycle_count !== 64'd20) begin failed++; $display("FAIL multi_count: got %0d want 20", cycle_count); end
    tests++; if (armed !== 4'b0000) begin failed++; $display("FAIL multi_disarm: got %b want 0000", armed); end
    step_n = 5; resume = 1; step_req = 1; tick(); resume = 0; step_req = 0;
    tests++; if (state !== 2'd1) begin failed++; $display("FAIL step_wins: got %0d want 1", state); end
  endtask

  task automatic test_clk_en_and_reset();
    int e0;
    tick();
    tests++; if (cycle_count !== 64'd21) begin failed++; $display("FAIL step_run: got %0d want 21", cycle_count); end
    clk_en = 0; e0 = edges;
    repeat (4) tick();
    tests++; if (edges != e0) begin failed++; $display("FAIL en0_edges: got %0d want %0d", edges, e0); end
    tests++; if (cycle_count !== 64'd21 || state !== 2'd1) begin
      failed++; $display("FAIL en0_hold: got %0d/%0d want 21/1", cycle_count, state); end
    clk_en = 1; tick();
    sys_rst = 1; tick();
    tests++; if (state !== 2'd0 || cycle_count !== 64'd0 || halt_cause !== 6'd0 ||
                 armed !== 4'd0 || cnt_ovf !== 1'b0 || task_clk_ce !== 1'b0) begin
      failed++; $display("FAIL mid_step_rst: got st=%0d cnt=%0d cause=%b arm=%b ovf=%b ce=%b",
                         state, cycle_count, halt_cause, armed, cnt_ovf, task_clk_ce); end
    sys_rst = 0; clk_en = 0; tick();
  endtask

  task automatic test_wrap();
    int e0;
    s_rst = 0; s_en = 1; e0 = s_edges;
    repeat (17) tick();
    s_en = 0;
    tick();
    tests++; if (s_count !== 4'd1) begin failed++; $display("FAIL wrap_count: got %0d want 1", s_count); end
    tests++; if (s_ovf !== 1'b1) begin failed++; $display("FAIL wrap_ovf: got %b want 1", s_ovf); end
    tests++; if (s_edges - e0 != 17) begin failed++; $display("FAIL wrap_edges: got %0d want 17", s_edges - e0); end
  endtask

  task automatic test_random();
    sys_rst = 1; tick(); sys_rst = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 12 == 0) begin
        for (int i = 0; i < 4; i++) bp_value[i*64 +: 64] = m_cnt + 64'($urandom_range(0, 8));
      end
      clk_en = ($urandom_range(0, 7) != 0);
      difftest_break = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < 4; i++) begin
        bp_arm[i] = ($urandom_range(0, 5) == 0);
        bp_disarm[i] = ($urandom_range(0, 9) == 0);
      end
      resume = ($urandom_range(0, 3) == 0);
      step_req = ($urandom_range(0, 4) == 0);
      step_n = 16'($urandom_range(0, 4));
      sys_rst = ($urandom_range(0, 199) == 0);
      #1;
      tests++; if (task_clk_ce !== mdl_ce()) begin
        failed++; $display("FAIL rnd_ce c=%0d: got %b want %b", c, task_clk_ce, mdl_ce()); end
      tick();
      tests++; if (state !== 2'(m_state)) begin
        failed++; $display("FAIL rnd_state c=%0d: got %0d want %0d", c, state, m_state); end
      tests++; if (cycle_count !== m_cnt) begin
        failed++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, cycle_count, m_cnt); end
      tests++; if (halt_cause !== m_cause) begin
        failed++; $display("FAIL rnd_cause c=%0d: got %b want %b", c, halt_cause, m_cause); end
      tests++; if (armed !== m_armed || cnt_ovf !== m_ovf) begin
        failed++; $display("FAIL rnd_armed c=%0d: got %b/%b want %b/%b", c, armed, cnt_ovf, m_armed, m_ovf); end
    end
    sys_rst = 0; bp_arm = 0; bp_disarm = 0; resume = 0; step_req = 0; difftest_break = 0;
  endtask

  initial begin
    test_reset();
    test_breakpoint();
    test_step();
    test_ext_break();
    test_multi_hit();
    test_clk_en_and_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
